// File: rtl/pes_gray_counter_if.sv
// Control and status bundle for pes_gray_counter: step/load controls in,
// binary/Gray count and terminal flags out.
interface pes_gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             ld;
   logic [WIDTH-1:0] ld_b;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] g;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, ld, ld_b,
      input  b, g, tc, wrap
   );

   modport slave (
      input  en, up, ld, ld_b,
      output b, g, tc, wrap
   );
endinterface

// File: rtl/pes_gray_counter.sv
// Registered up/down binary counter with a Gray-coded view registered on the
// same edge, synchronous load, wrap or saturate at the ends, and end flags.
module pes_gray_counter #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit               SATURATE = 1'b0
) (
   input logic              clk,
   input logic              rst_n,
   pes_gray_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX       = '1;
   localparam logic [WIDTH-1:0] ZERO      = '0;
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] RST_GRAY  = RST_VAL ^ (RST_VAL >> 1);

   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] g_q;
   logic             wrap_q;
   logic [WIDTH-1:0] b_next;
   logic             wrap_next;

   // Load beats enable beats hold; the end-of-range case either wraps
   // (flagging it) or sticks, depending on SATURATE.
   always_comb begin
      b_next    = b_q;
      wrap_next = 1'b0;
      if (bus.ld) begin
         b_next = bus.ld_b;
      end else if (bus.en) begin
         if (bus.up) begin
            if (b_q != MAX) begin
               b_next = b_q + ONE;
            end else if (!SATURATE) begin
               b_next    = ZERO;
               wrap_next = 1'b1;
            end
         end else begin
            if (b_q != ZERO) begin
               b_next = b_q - ONE;
            end else if (!SATURATE) begin
               b_next    = MAX;
               wrap_next = 1'b1;
            end
         end
      end
   end

   // Gray is derived from the next binary value so both views change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q    <= RST_VAL;
         g_q    <= RST_GRAY;
         wrap_q <= 1'b0;
      end else begin
         b_q    <= b_next;
         g_q    <= b_next ^ (b_next >> 1);
         wrap_q <= wrap_next;
      end
   end

   assign bus.b    = b_q;
   assign bus.g    = g_q;
   assign bus.wrap = wrap_q;
   assign bus.tc   = (bus.up && (b_q == MAX)) || (!bus.up && (b_q == ZERO));

endmodule

// File: tb/tb_pes_gray_counter.sv
// Directed self-checking bench: three counter instances cover wrap mode,
// saturate mode and an 8-bit counter with a non-zero reset value.
module tb_pes_gray_counter;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [3:0] prev_g;
   logic [3:0] exp_b;

   pes_gray_counter_if #(.WIDTH(4)) ifa ();
   pes_gray_counter_if #(.WIDTH(4)) ifs ();
   pes_gray_counter_if #(.WIDTH(8)) ifc ();

   pes_gray_counter #(.WIDTH(4), .RST_VAL(4'd0), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   pes_gray_counter #(.WIDTH(4), .RST_VAL(4'd0), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(ifs)
   );
   pes_gray_counter #(.WIDTH(8), .RST_VAL(8'hFE), .SATURATE(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   // Advance a number of rising edges and settle just past the last one.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] gray4(input logic [3:0] v);
      return v ^ (v >> 1);
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      ifa.en = 0; ifa.up = 0; ifa.ld = 0; ifa.ld_b = '0;
      ifs.en = 0; ifs.up = 0; ifs.ld = 0; ifs.ld_b = '0;
      ifc.en = 0; ifc.up = 0; ifc.ld = 0; ifc.ld_b = '0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_a_b",    ifa.b, 4'd0);
      checkOutput("rst_a_g",    ifa.g, 4'd0);
      checkOutput("rst_a_wrap", ifa.wrap, 1'b0);
      checkOutput("rst_a_tc",   ifa.tc, 1'b1);
      checkOutput("rst_c_b",    ifc.b, 8'hFE);
      checkOutput("rst_c_g",    ifc.g, 8'h81);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Full up-count with wrap back to zero.
      ifa.en = 1; ifa.up = 1;
      prev_g = ifa.g;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1);
         exp_b = 4'(i);
         checkOutput("up_b", ifa.b, exp_b);
         checkOutput("up_g", ifa.g, gray4(exp_b));
         checkOutput("up_hamming", $countones(ifa.g ^ prev_g), 1);
         checkOutput("up_wrap", ifa.wrap, (i == 16));
         checkOutput("up_tc", ifa.tc, (exp_b == 4'd15));
         prev_g = ifa.g;
      end
      applyStimulus(1);
      checkOutput("up_after_wrap_b", ifa.b, 4'd1);
      checkOutput("up_after_wrap_wrap", ifa.wrap, 1'b0);

      // Down-count wrap from zero.
      ifa.en = 0; ifa.ld = 1; ifa.ld_b = 4'd0;
      applyStimulus(1);
      ifa.ld = 0; ifa.en = 1; ifa.up = 0;
      #1;
      checkOutput("dn_tc_at0", ifa.tc, 1'b1);
      applyStimulus(1);
      checkOutput("dn_b", ifa.b, 4'd15);
      checkOutput("dn_g", ifa.g, 4'b1000);
      checkOutput("dn_wrap", ifa.wrap, 1'b1);
      checkOutput("dn_tc_at15", ifa.tc, 1'b0);
      applyStimulus(1);
      checkOutput("dn_b2", ifa.b, 4'd14);
      checkOutput("dn_g2", ifa.g, 4'b1001);
      checkOutput("dn_wrap2", ifa.wrap, 1'b0);

      // Back-to-back wraps with a direction flip produce two pulses.
      ifa.en = 0; ifa.ld = 1; ifa.ld_b = 4'd0;
      applyStimulus(1);
      ifa.ld = 0; ifa.en = 1; ifa.up = 0;
      applyStimulus(1);
      checkOutput("b2b_b1", ifa.b, 4'd15);
      checkOutput("b2b_wrap1", ifa.wrap, 1'b1);
      ifa.up = 1;
      applyStimulus(1);
      checkOutput("b2b_b2", ifa.b, 4'd0);
      checkOutput("b2b_wrap2", ifa.wrap, 1'b1);
      ifa.en = 0;

      // Saturating instance holds at both ends.
      ifs.ld = 1; ifs.ld_b = 4'd14;
      applyStimulus(1);
      checkOutput("sat_ld_b", ifs.b, 4'd14);
      ifs.ld = 0; ifs.en = 1; ifs.up = 1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("sat_up_b", ifs.b, 4'd15);
         checkOutput("sat_up_g", ifs.g, 4'b1000);
         checkOutput("sat_up_wrap", ifs.wrap, 1'b0);
         checkOutput("sat_up_tc", ifs.tc, 1'b1);
      end
      ifs.ld = 1; ifs.ld_b = 4'd1; ifs.up = 0;
      applyStimulus(1);
      ifs.ld = 0;
      applyStimulus(2);
      checkOutput("sat_dn_b", ifs.b, 4'd0);
      checkOutput("sat_dn_wrap", ifs.wrap, 1'b0);
      checkOutput("sat_dn_tc", ifs.tc, 1'b1);
      ifs.en = 0;

      // Load wins over a simultaneous enabled step.
      ifa.ld = 1; ifa.ld_b = 4'd9; ifa.en = 1; ifa.up = 1;
      applyStimulus(1);
      checkOutput("ld_prio_b", ifa.b, 4'd9);
      checkOutput("ld_prio_g", ifa.g, 4'b1101);
      checkOutput("ld_prio_wrap", ifa.wrap, 1'b0);

      // Hold when disabled.
      ifa.ld = 0; ifa.en = 0;
      applyStimulus(2);
      checkOutput("hold_b", ifa.b, 4'd9);
      checkOutput("hold_g", ifa.g, 4'b1101);

      // Asynchronous reset mid-count, then resume from the reset value.
      ifa.ld = 1; ifa.ld_b = 4'd4;
      applyStimulus(1);
      ifa.ld = 0; ifa.en = 1; ifa.up = 1;
      applyStimulus(1);
      checkOutput("ar_pre_b", ifa.b, 4'd5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ar_b", ifa.b, 4'd0);
      checkOutput("ar_g", ifa.g, 4'd0);
      checkOutput("ar_wrap", ifa.wrap, 1'b0);
      checkOutput("ar_c_b", ifc.b, 8'hFE);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1);
      checkOutput("ar_resume_b", ifa.b, 4'd1);
      checkOutput("ar_resume_g", ifa.g, 4'd1);
      ifa.en = 0;

      // 8-bit instance wraps from FF to 00.
      ifc.en = 1; ifc.up = 1;
      applyStimulus(1);
      checkOutput("w8_b1", ifc.b, 8'hFF);
      checkOutput("w8_g1", ifc.g, 8'h80);
      checkOutput("w8_wrap1", ifc.wrap, 1'b0);
      checkOutput("w8_tc1", ifc.tc, 1'b1);
      applyStimulus(1);
      checkOutput("w8_b2", ifc.b, 8'h00);
      checkOutput("w8_g2", ifc.g, 8'h00);
      checkOutput("w8_wrap2", ifc.wrap, 1'b1);
      applyStimulus(1);
      checkOutput("w8_b3", ifc.b, 8'h01);
      checkOutput("w8_g3", ifc.g, 8'h01);
      checkOutput("w8_wrap3", ifc.wrap, 1'b0);
      ifc.en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
